// File: rtl/score_display_pkg.sv
// Shared constants for the score display: active-low segment patterns and FSM states.
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encode.sv
// One 7-segment digit: BCD value with blank and dash overrides, polarity selectable.
module seg7_encode
  import score_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] seg_al;

  // Dash wins over blank so an overflow shows on every digit.
  always_comb begin
    seg_al = SEG_BLANK;
    if (dash) begin
      seg_al = SEG_DASH;
    end else if (blank) begin
      seg_al = SEG_BLANK;
    end else if (bcd <= 4'd9) begin
      seg_al = SEG_DIGIT[bcd];
    end
  end

  assign seg = ACTIVE_LOW ? seg_al : ~seg_al;

endmodule

// File: rtl/score_display.sv
// Binary score to parallel 7-segment digits via a bit-serial double-dabble converter.
// Handshake: load is a one-cycle request; a load while busy is queued (newest score wins) and runs right after the current result latches; done pulses once per result.
module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_W       = 7,
  parameter int DIGITS        = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  load,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output state_t                dbg_state
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(SCORE_W + 1);

  state_t               state;
  logic [SCORE_W-1:0]   bin_q;
  logic [SCORE_W-1:0]   pend_score;
  logic                 pending;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_q;
  logic                 ovf_now;
  logic                 seen;
  logic [DIGITS-1:0]    blank_v;
  logic [7*DIGITS-1:0]  seg_next;

  assign dbg_state = state;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i <= DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // ovf_q catches a carry out of the extra nibble when the score is far too big.
  assign ovf_now = ovf_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);

  always_comb begin
    seen    = 1'b0;
    blank_v = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (bcd_q[4*i +: 4] != 4'd0);
      blank_v[i] = BLANK_LEADING && (i != 0) && !seen;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_encode #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
      .bcd   (bcd_q[4*g +: 4]),
      .blank (blank_v[g]),
      .dash  (ovf_now),
      .seg   (seg_next[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bin_q      <= '0;
      pend_score <= '0;
      pending    <= 1'b0;
      bcd_q      <= '0;
      cnt        <= '0;
      ovf_q      <= 1'b0;
      seg        <= {(7*DIGITS){ACTIVE_LOW}};
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && state != ST_IDLE) begin
        pending    <= 1'b1;
        pend_score <= score;
      end
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin_q <= score;
            bcd_q <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          ovf_q          <= ovf_q | bcd_adj[BCD_W-1];
          cnt            <= cnt + 1'b1;
          if (cnt == CNT_W'(SCORE_W - 1)) begin
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          seg      <= seg_next;
          overflow <= ovf_now;
          done     <= 1'b1;
          if (pending || load) begin
            bin_q   <= load ? score : pend_score;
            bcd_q   <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            pending <= 1'b0;
            state   <= ST_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display across four parameter sets, scoreboard checked on done.
module tb_score_display;
  import score_display_pkg::*;

  localparam int SW  = 7;
  localparam int LAT = SW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] score = '0;
  logic [3:0]    load_v = '0;

  logic [27:0] seg_a, seg_c, seg_d;
  logic [13:0] seg_b;
  logic [3:0]  busy_v, done_v, ovf_v;
  state_t      st_a, st_b, st_c, st_d;

  logic [28:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_display #(.SCORE_W(SW), .DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_a (
    .clk(clk), .rst(rst), .score(score), .load(load_v[0]), .seg(seg_a),
    .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]), .dbg_state(st_a));
  score_display #(.SCORE_W(SW), .DIGITS(2), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_b (
    .clk(clk), .rst(rst), .score(score), .load(load_v[1]), .seg(seg_b),
    .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]), .dbg_state(st_b));
  score_display #(.SCORE_W(SW), .DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u_c (
    .clk(clk), .rst(rst), .score(score), .load(load_v[2]), .seg(seg_c),
    .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]), .dbg_state(st_c));
  score_display #(.SCORE_W(SW), .DIGITS(4), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) u_d (
    .clk(clk), .rst(rst), .score(score), .load(load_v[3]), .seg(seg_d),
    .busy(busy_v[3]), .done(done_v[3]), .overflow(ovf_v[3]), .dbg_state(st_d));

  // {overflow, seg zero-extended to four digits}
  function automatic logic [28:0] cur_out(input int w);
    case (w)
      0:       return {ovf_v[0], seg_a};
      1:       return {ovf_v[1], 14'b0, seg_b};
      2:       return {ovf_v[2], seg_c};
      default: return {ovf_v[3], seg_d};
    endcase
  endfunction

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [28:0] model(input int sc, input int nd, input bit al, input bit bl);
    logic [27:0] s;
    logic [6:0]  d;
    int lim, top, tmp, pw;
    s = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (sc >= lim) begin
      for (int i = 0; i < nd; i++) s[7*i +: 7] = al ? 7'b0111111 : 7'b1000000;
      return {1'b1, s};
    end
    top = 0;
    tmp = sc;
    for (int i = 0; i < nd; i++) begin
      if (tmp % 10 != 0) top = i;
      tmp = tmp / 10;
    end
    pw = 1;
    for (int i = 0; i < nd; i++) begin
      d = (bl && i > top) ? 7'b1111111 : enc((sc / pw) % 10);
      s[7*i +: 7] = al ? d : ~d;
      pw = pw * 10;
    end
    return {1'b0, s};
  endfunction

  task automatic chk(input string tag, input logic [28:0] got, input logic [28:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start(input int w, input int sc);
    @(negedge clk);
    score     = SW'(sc);
    load_v[w] = 1'b1;
    @(negedge clk);
    load_v    = '0;
  endtask

  // Waits for done (checking the current cycle first), then scores latency, result, busy and pulse width.
  task automatic wait_done(input string tag, input int w, input int lat, input bit busy_after);
    int n;
    bit busy_gap;
    logic [28:0] exp;
    n = 0;
    busy_gap = 1'b0;
    while (!done_v[w] && n < 40) begin
      if (!busy_v[w]) busy_gap = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 29'(done_v[w]), 29'd1);
    chk({tag, "_latency"}, 29'(n), 29'(lat));
    chk({tag, "_busy_held"}, 29'(busy_gap), 29'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 29'(exp_q.size()), 29'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_result"}, cur_out(w), exp);
    end
    chk({tag, "_busy_after"}, 29'(busy_v[w]), 29'(busy_after));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 29'(done_v[w]), 29'd0);
  endtask

  task automatic run(input string tag, input int w, input int sc, input logic [28:0] exp);
    start(w, sc);
    exp_q.push_back(exp);
    wait_done(tag, w, LAT, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    bit saw_done;

    repeat (3) @(negedge clk);
    chk("rst_out_a", {ovf_v[0], seg_a}, {1'b0, 28'hFFFFFFF});
    chk("rst_out_d", {ovf_v[3], seg_d}, 29'd0);
    chk("rst_flags", {25'd0, busy_v | done_v}, 29'd0);
    chk("rst_state", 29'(st_a), 29'(ST_IDLE));
    rst = 1'b0;

    run("s42", 0, 42, {1'b0, 7'h7F, 7'h7F, 7'b0011001, 7'b0100100});
    run("s0", 0, 0, {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    run("noblank7", 2, 7, {1'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
    run("d2_100", 1, 100, {1'b1, 14'b0, 7'b0111111, 7'b0111111});
    run("d2_99", 1, 99, {1'b0, 14'b0, 7'b0010000, 7'b0010000});
    run("d2_127", 1, 127, model(127, 2, 1'b1, 1'b1));
    run("ahi8", 3, 8, {1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111});
    run("s127", 0, 127, {1'b0, 7'h7F, 7'b1111001, 7'b0100100, 7'b1111000});
    run("s100", 0, 100, model(100, 4, 1'b1, 1'b1));

    // Load while busy: newest score queued, first result still delivered.
    start(0, 5);
    exp_q.push_back({1'b0, 7'h7F, 7'h7F, 7'h7F, 7'b0010010});
    exp_q.push_back({1'b0, 7'h7F, 7'h7F, 7'b0010000, 7'b0010000});
    repeat (2) @(negedge clk);
    score = SW'(99);
    load_v[0] = 1'b1;
    @(negedge clk);
    load_v = '0;
    wait_done("pend_first", 0, LAT - 3, 1'b1);
    wait_done("pend_second", 0, LAT - 1, 1'b0);

    // Load landing on the latch edge restarts straight away.
    start(0, 17);
    exp_q.push_back(model(17, 4, 1'b1, 1'b1));
    exp_q.push_back(model(63, 4, 1'b1, 1'b1));
    repeat (LAT - 1) @(negedge clk);
    score = SW'(63);
    load_v[0] = 1'b1;
    @(negedge clk);
    load_v = '0;
    wait_done("latch_load_first", 0, 0, 1'b1);
    wait_done("latch_load_second", 0, LAT - 1, 1'b0);

    // seg must hold the last result while the next conversion runs.
    start(0, 88);
    repeat (3) @(negedge clk);
    chk("seg_hold", cur_out(0), model(63, 4, 1'b1, 1'b1));

    rst = 1'b1;
    #1;
    chk("async_rst_seg", cur_out(0), {1'b0, 28'hFFFFFFF});
    chk("async_rst_busy", 29'(busy_v[0]), 29'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_v[0]) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) saw_done = 1'b1;
    end
    chk("rst_abort_no_done", 29'(saw_done), 29'd0);
    chk("rst_abort_idle", 29'(st_a), 29'(ST_IDLE));
    run("after_rst13", 0, 13, {1'b0, 7'h7F, 7'h7F, 7'b1111001, 7'b0110000});

    for (int k = 0; k < 6; k++) begin
      sc = $urandom_range(0, (1 << SW) - 1);
      case (k % 3)
        0: run("rand_a", 0, sc, model(sc, 4, 1'b1, 1'b1));
        1: run("rand_c", 2, sc, model(sc, 4, 1'b1, 1'b0));
        default: run("rand_d", 3, sc, model(sc, 4, 1'b0, 1'b1));
      endcase
    end

    chk("queue_drained", 29'(exp_q.size()), 29'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
